// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//
// Owns the single write port (we3/a3/wd3) of the 32x32 register file.
// Two requesters share it: core writeback (requester 0) and the debug/loader
// port (requester 1). A sequenced clear engine zeroes x1..x31 on command.
//
// Build option: define ARB_ROUND_ROBIN_EN to break ties round-robin instead
// of fixed priority with aging (the age counter is then not built).
//
// Parameters:
//   MAX_WAIT    cycles requester 1 may wait while requesting before it wins a tie (1..15)
//   AGE_W       age counter width, 2**AGE_W > MAX_WAIT
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/addr0/data0    core writeback request, gnt0 grant (combinational)
//   req1/addr1/data1    debug write request, gnt1 grant (combinational)
//   clear_start         pulse that starts the clear sequence
//   busy                high while the clear sequence runs
//   clear_done          one-cycle pulse in the first cycle after the clear
//   we3/a3/wd3          registered register-file write port
module regfile_wr_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AGE_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [4:0]  addr0,
    input  logic [31:0] data0,
    output logic        gnt0,
    input  logic        req1,
    input  logic [4:0]  addr1,
    input  logic [31:0] data1,
    output logic        gnt1,
    input  logic        clear_start,
    output logic        busy,
    output logic        clear_done,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic       win1;    // requester 1 wins when both request

`ifdef ARB_ROUND_ROBIN_EN
    // last1 = 1 means requester 1 was granted most recently; starts at 1 so
    // requester 0 takes the first tie.
    logic last1;

    assign win1 = ~last1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last1 <= 1'b1;
        end else if (gnt0) begin
            last1 <= 1'b0;
        end else if (gnt1) begin
            last1 <= 1'b1;
        end
    end
`else
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] age;

    assign win1 = (age == AGE_MAX);

    // Age counts cycles requester 1 waits; frozen during CLEAR so a waiting
    // debug request keeps its seniority across a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else if (state == CLEAR) begin
            age <= age;
        end else if (!req1 || gnt1) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        busy      = 1'b0;
        case (state)
            ARB: begin
                // clear_start takes precedence over any pending request
                if (clear_start) begin
                    state_nxt = CLEAR;
                end else if (req0 && req1) begin
                    gnt1 = win1;
                    gnt0 = ~win1;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (idx == 5'd31) begin
                    state_nxt = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // ---- write-port register stage: grant in cycle N drives the port in N+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3        <= 1'b0;
            a3         <= '0;
            wd3        <= '0;
            idx        <= 5'd1;
            clear_done <= 1'b0;
        end else begin
            we3        <= 1'b0;
            clear_done <= 1'b0;
            if (state == CLEAR) begin
                we3        <= 1'b1;
                a3         <= idx;
                wd3        <= '0;
                idx        <= (idx == 5'd31) ? 5'd1 : idx + 5'd1;
                clear_done <= (idx == 5'd31);
            end else if (gnt0) begin
                // x0 is hardwired zero: handshake completes, no write issued
                we3 <= (addr0 != 5'd0);
                a3  <= addr0;
                wd3 <= data0;
            end else if (gnt1) begin
                we3 <= (addr1 != 5'd0);
                a3  <= addr1;
                wd3 <= data1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, clear_start;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1, busy, clear_done, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int total = 0;
    int bad   = 0;

    regfile_wr_arbiter #(.MAX_WAIT(4), .AGE_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .we3(we3), .a3(a3), .wd3(wd3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expected gnt1 per cycle with both requesters held
`ifdef ARB_ROUND_ROBIN_EN
    logic [5:0] tie_g1 = 6'b101010;   // bit k = cycle k: 0,1,0,1,0,1
`else
    logic [5:0] tie_g1 = 6'b010000;   // 0,0,0,0,1,0
`endif

    initial begin
        logic [4:0] prev_a;
        rst_n = 1'b0; req0 = 0; req1 = 0; clear_start = 0;
        addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        prev_a = 0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", clear_done, 0);
        rst_n = 1'b1;

        // both requesters held: aging / round-robin tie break
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req0 = 1; addr0 = 5'd3; data0 = 32'h30;
                req1 = 1; addr1 = 5'd7; data1 = 32'h70;
            end else begin
                chk("tie_we3", we3, 1);
                chk("tie_a3", a3, prev_a);
            end
            #1;
            chk("tie_gnt1", gnt1, tie_g1[k]);
            chk("tie_gnt0", gnt0, !tie_g1[k]);
            prev_a = tie_g1[k] ? 5'd7 : 5'd3;
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        chk("tie_last_a3", a3, prev_a);

        // single requester 0
        @(negedge clk);
        req0 = 1; addr0 = 5'd5; data0 = 32'h0000_00AA;
        #1;
        chk("r0_gnt0", gnt0, 1);
        chk("r0_gnt1", gnt1, 0);
        @(negedge clk);
        req0 = 0;
        chk("r0_we3", we3, 1);
        chk("r0_a3", a3, 5);
        chk("r0_wd3", wd3, 32'hAA);
        #1;
        chk("idle_gnt0", gnt0, 0);
        @(negedge clk);
        chk("idle_we3", we3, 0);
        chk("idle_a3", a3, 5);
        chk("idle_wd3", wd3, 32'hAA);

        // requester 1 writing x0
        req1 = 1; addr1 = 5'd0; data1 = 32'hFFFF_FFFF;
        #1;
        chk("x0_gnt1", gnt1, 1);
        chk("x0_gnt0", gnt0, 0);
        @(negedge clk);
        req1 = 0;
        chk("x0_we3", we3, 0);

        // clear with req0 held, plus a clear_start retrigger at index 10
        @(negedge clk);
        clear_start = 1; req0 = 1; addr0 = 5'd9; data0 = 32'h99;
        #1;
        chk("cs_gnt0", gnt0, 0);
        chk("cs_busy", busy, 0);
        @(negedge clk);
        clear_start = 0;
        chk("clr_busy0", busy, 1);
        #1;
        chk("clr_gnt0_0", gnt0, 0);
        for (int i = 1; i <= 31; i++) begin
            @(negedge clk);
            clear_start = (i == 9);   // CLEAR is at index 10 this cycle
            chk("clr_we3", we3, 1);
            chk("clr_a3", a3, i);
            chk("clr_wd3", wd3, 0);
            chk("clr_busy", busy, (i < 31));
            chk("clr_done", clear_done, (i == 31));
            #1;
            chk("clr_gnt0", gnt0, (i == 31));
        end
        @(negedge clk);
        req0 = 0;
        chk("post_we3", we3, 1);
        chk("post_a3", a3, 9);
        chk("post_wd3", wd3, 32'h99);
        chk("post_done", clear_done, 0);
        chk("post_busy", busy, 0);
        @(negedge clk);
        chk("post_done2", clear_done, 0);

        // reset in the middle of a clear
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
        end
        chk("mid_a3", a3, 15);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we3", we3, 0);
        chk("arst_busy", busy, 0);
        chk("arst_a3", a3, 0);
        chk("arst_done", clear_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_done", clear_done, 0);
        chk("rel_busy", busy, 0);
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        chk("re_busy", busy, 1);
        @(negedge clk);
        chk("re_we3", we3, 1);
        chk("re_a3", a3, 1);
        for (int j = 2; j <= 31; j++) begin
            @(negedge clk);
        end
        chk("re_a3_end", a3, 31);
        chk("re_done", clear_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port (we3/a3/wd3) of the 32x32 register file in the multi-cycle core.
- Shares that port between two requesters: core writeback (requester 0) and the debug/loader port (requester 1).
- Arbitration is fixed priority with aging, so the debug port cannot starve.
- Includes a sequenced clear engine that zeroes x1..x31 on command, used for test reload without a full reset.

Parameters:
- MAX_WAIT, 4: cycles requester 1 may wait while requesting before it takes priority; legal range 1..15.
- AGE_W, 4: width of the age counter; must satisfy 2^AGE_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  core writeback request.
- addr0  in  5  core destination register.
- data0  in  32  core write data.
- gnt0  out  1  core grant (combinational).
- req1  in  1  debug write request.
- addr1  in  5  debug destination register.
- data1  in  32  debug write data.
- gnt1  out  1  debug grant (combinational).
- clear_start  in  1  single-cycle pulse that starts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- clear_done  out  1  one-cycle pulse when the clear sequence completes.
- we3  out  1  register-file write enable (registered).
- a3  out  5  register-file write address (registered).
- wd3  out  32  register-file write data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is ARB, age=0, clear index=1.
  - we3=0, a3=0, wd3=0, busy=0, clear_done=0.
- Handshake:
  - A requester holds req/addr/data stable until it sees gnt high in a cycle.
  - The transfer completes at the rising edge that ends that cycle.
  - gnt0 and gnt1 are never high together, and both are 0 unless state is ARB.
- Latency:
  - A grant in cycle N drives we3/a3/wd3 in cycle N+1.
  - The register file updates at the end of N+1.
  - When no grant occurs, the next cycle has we3=0 and a3/wd3 keep their previous values.
- x0 writes: a grant with addr=0 still completes the handshake, but the following cycle has we3=0.
- ARB state priority:
  - If only one requester is asserting req, it is granted.
  - If both are asserting req and age==MAX_WAIT, requester 1 wins; otherwise requester 0 wins.
- Age counter:
  - Increments, saturating at MAX_WAIT, each cycle req1=1 and gnt1=0.
  - Clears to 0 on gnt1, or whenever req1=0.
- ARB to CLEAR transition:
  - clear_start=1 in ARB moves the state to CLEAR on the next edge.
  - In that same cycle, clear_start overrides arbitration: gnt0=gnt1=0.
- CLEAR state:
  - busy=1 and both gnts are 0.
  - Each cycle writes we3=1, a3=index, wd3=0 on the registered outputs, covering index 1..31 in order.
  - 31 writes occupy 31 consecutive cycles, starting the cycle after entry.
  - The index increments each cycle.
  - After index 31 is issued, the state returns to ARB, index resets to 1, and clear_done pulses for one cycle in the first ARB cycle.
  - clear_start is ignored while in CLEAR.
- Age during CLEAR: age holds its value; requesters that are waiting keep req asserted.
- Reset mid-CLEAR: the sequence aborts immediately, all outputs take reset values, and clear_done does not pulse.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Ties are broken round-robin, and the most recently granted requester loses the next tie.
  - The last-grant flag resets to 1, so requester 0 wins the first tie.
  - The age counter and MAX_WAIT are unused, and the aging logic is not instantiated.
- Undefined: fixed priority with aging, as specified above.

Test Plan:
- Only req0 asserts, with addr0=5, data0=0x0000_00AA → gnt0 in cycle N; cycle N+1 shows we3=1, a3=5, wd3=0xAA; no gnt1.
- req0 and req1 held continuously (addr0=3, addr1=7) with MAX_WAIT=4 → gnt0 in 4 cycles, then gnt1 in the 5th, then age=0 and gnt0 resumes. With ARB_ROUND_ROBIN_EN defined, grants alternate 0,1,0,1.
- req1 with addr1=0, data1=0xFFFF_FFFF → gnt1 high; next cycle we3=0.
- clear_start pulse with req0 held → busy high for 31 cycles; we3=1 with a3 stepping 1..31 and wd3=0; gnt0=0 throughout; clear_done pulses, then gnt0 is granted in the same cycle.
- clear_start during CLEAR at index 10 → ignored; the sequence still ends at 31 with a single clear_done.
- rst_n low at index 15 of CLEAR → we3, busy and a3 go to 0 asynchronously; after release the state is ARB and a new clear starts at index 1.
